// File: rtl/rc5_engine_scheduler_if.sv
// Client, key-expansion and round-engine signals of the RC5 engine scheduler.
interface rc5_engine_scheduler_if #(
  parameter int W = 32
);
  // A request or response moves on a rising edge where its valid and ready are both 1; valid and
  // payload hold until that edge. exp_start/exp_done/eng_start/eng_done are single-cycle pulses.
  logic           key_update;
  logic [1:0]     req_valid;
  logic [1:0]     req_mode;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [1:0]     req_ready;
  logic [1:0]     resp_valid;
  logic [W-1:0]   resp_a;
  logic [W-1:0]   resp_b;
  logic [1:0]     resp_ready;
  logic           exp_start;
  logic           exp_done;
  logic           eng_start;
  logic           eng_mode;
  logic [W-1:0]   eng_a;
  logic [W-1:0]   eng_b;
  logic [W-1:0]   eng_res_a;
  logic [W-1:0]   eng_res_b;
  logic           eng_done;
  logic           s_owner;
  logic           key_valid;
  logic [1:0]     dbg_state;

  modport slave (
    input  key_update, req_valid, req_mode, req_a, req_b, resp_ready,
           exp_done, eng_res_a, eng_res_b, eng_done,
    output req_ready, resp_valid, resp_a, resp_b, exp_start, eng_start,
           eng_mode, eng_a, eng_b, s_owner, key_valid, dbg_state
  );

  modport master (
    output key_update, req_valid, req_mode, req_a, req_b, resp_ready,
           exp_done, eng_res_a, eng_res_b, eng_done,
    input  req_ready, resp_valid, resp_a, resp_b, exp_start, eng_start,
           eng_mode, eng_a, eng_b, s_owner, key_valid, dbg_state
  );
endinterface

// File: rtl/rc5_engine_scheduler.sv
// Sequences key expansion and block operations on the shared RC5 datapath and
// arbitrates two block clients round-robin, one block in flight at a time.
module rc5_engine_scheduler #(
  parameter int W    = 32,
  parameter int NREQ = 2
) (
  input logic                   clk,
  input logic                   rst,
  rc5_engine_scheduler_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXP   = 2'd1,
    CRYPT = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  logic            key_stale;
  logic            rr_ptr;
  logic            owner_id;
  logic            op_mode;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W-1:0]    res_a;
  logic [W-1:0]    res_b;
  logic            exp_start;
  logic            eng_start;
  logic            s_owner;
  logic            key_valid;
  logic [NREQ-1:0] resp_valid;
  logic [NREQ-1:0] grant;
  logic            gnt_id;

  // rr_ptr remembers the last contested winner, so the other client wins the next tie.
  always_comb begin
    gnt_id = (&bus.req_valid) ? ~rr_ptr : bus.req_valid[1];
    grant  = '0;
    if (state == IDLE && !key_stale && |bus.req_valid) begin
      grant = NREQ'(1) << gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      key_stale  <= 1'b1;
      rr_ptr     <= 1'b1;
      owner_id   <= 1'b0;
      op_mode    <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      res_a      <= '0;
      res_b      <= '0;
      exp_start  <= 1'b0;
      eng_start  <= 1'b0;
      s_owner    <= 1'b0;
      key_valid  <= 1'b0;
      resp_valid <= '0;
    end else begin
      exp_start <= 1'b0;
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (key_stale) begin
            state     <= EXP;
            exp_start <= 1'b1;
          end else if (|grant) begin
            op_mode  <= bus.req_mode[gnt_id];
            op_a     <= gnt_id ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
            op_b     <= gnt_id ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
            owner_id <= gnt_id;
            if (&bus.req_valid) rr_ptr <= gnt_id;
            state     <= CRYPT;
            eng_start <= 1'b1;
            s_owner   <= 1'b1;
          end
        end
        EXP: begin
          if (bus.exp_done) begin
            key_stale <= 1'b0;
            key_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        CRYPT: begin
          if (bus.eng_done) begin
            res_a      <= bus.eng_res_a;
            res_b      <= bus.eng_res_b;
            resp_valid <= NREQ'(1) << owner_id;
            s_owner    <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready[owner_id]) begin
            resp_valid <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A key rewrite wins over a finishing expansion in the same cycle.
      if (bus.key_update) begin
        key_stale <= 1'b1;
        key_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_a     = res_a;
  assign bus.resp_b     = res_b;
  assign bus.exp_start  = exp_start;
  assign bus.eng_start  = eng_start;
  assign bus.eng_mode   = op_mode;
  assign bus.eng_a      = op_a;
  assign bus.eng_b      = op_b;
  assign bus.s_owner    = s_owner;
  assign bus.key_valid  = key_valid;
  assign bus.dbg_state  = state;
endmodule

// File: tb/tb_rc5_engine_scheduler.sv
// Bench for rc5_engine_scheduler: stub expander/engine, per-scenario tasks and a result scoreboard.
module tb_rc5_engine_scheduler;
  localparam int W       = 32;
  localparam int EXP_DLY = 5;
  localparam int ENG_DLY = 4;
  localparam int SB_W    = 2*W + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [SB_W-1:0] exp_q[$];
  logic            model_ptr = 1'b1;
  logic [W-1:0]    cur_a[2];
  logic [W-1:0]    cur_b[2];
  logic [1:0]      cur_mode = 2'b00;

  logic         stub_eng_done = 1'b0;
  logic         stub_exp_done = 1'b0;
  logic [W-1:0] stub_res_a = '0;
  logic [W-1:0] stub_res_b = '0;
  logic [W-1:0] held_a = '0;
  logic [W-1:0] held_b = '0;
  int           eng_cnt = 0;
  int           exp_cnt = 0;

  rc5_engine_scheduler_if #(.W(W)) bus();
  rc5_engine_scheduler #(.W(W), .NREQ(2)) dut (.clk(clk), .rst(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Stub cores: expander answers EXP_DLY cycles after exp_start, engine inverts operands after ENG_DLY.
  assign bus.exp_done  = stub_exp_done;
  assign bus.eng_done  = stub_eng_done;
  assign bus.eng_res_a = stub_res_a;
  assign bus.eng_res_b = stub_res_b;

  always @(negedge clk) begin
    stub_exp_done = 1'b0;
    stub_eng_done = 1'b0;
    if (bus.exp_start) exp_cnt = EXP_DLY;
    else if (exp_cnt > 0) begin
      exp_cnt--;
      if (exp_cnt == 0) stub_exp_done = 1'b1;
    end
    if (bus.eng_start) begin
      eng_cnt = ENG_DLY;
      held_a  = ~bus.eng_a;
      held_b  = ~bus.eng_b;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        stub_eng_done = 1'b1;
        stub_res_a    = held_a;
        stub_res_b    = held_b;
      end
    end
  end

  task automatic drive_ops();
    bus.req_a    = {cur_a[1], cur_a[0]};
    bus.req_b    = {cur_b[1], cur_b[0]};
    bus.req_mode = cur_mode;
  endtask

  task automatic new_ops(input int r);
    cur_a[r]    = $urandom;
    cur_b[r]    = $urandom;
    cur_mode[r] = 1'($urandom_range(0, 1));
    drive_ops();
  endtask

  // Called at a negedge with requests driven; returns one negedge after the accepting edge.
  task automatic wait_grant(input int budget, output logic [1:0] g, output int waited);
    g = 2'b00;
    waited = 0;
    while (waited < budget) begin
      #1;
      g = bus.req_ready;
      if (g != 2'b00) break;
      @(negedge clk);
      waited++;
    end
    if (g != 2'b00) @(negedge clk);
  endtask

  task automatic wait_resp(input int budget, output int waited);
    waited = 0;
    while (bus.resp_valid == 2'b00 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic ack_resp(input logic [1:0] r);
    bus.resp_ready = r;
    @(negedge clk);
    bus.resp_ready = 2'b00;
  endtask

  task automatic test_reset();
    int rise;
    int pulses;
    #1 rst_n = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_a     = {32'h0, 32'h1234_5678};
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({bus.exp_start, bus.eng_start, bus.eng_mode, bus.s_owner, bus.key_valid,
         bus.resp_valid, bus.req_ready, bus.dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: exp_start=%b eng_start=%b key_valid=%b resp_valid=%b req_ready=%b state=%0d, want all 0",
               bus.exp_start, bus.eng_start, bus.key_valid, bus.resp_valid, bus.req_ready, bus.dbg_state);
    end
    n_checks++;
    if ({bus.eng_a, bus.eng_b, bus.resp_a, bus.resp_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: eng_a=%h resp_a=%h, want 0", bus.eng_a, bus.resp_a);
    end
    rst_n  = 1'b1;
    rise   = 0;
    pulses = 0;
    for (int c = 1; c <= 20 && rise == 0; c++) begin
      @(negedge clk);
      #1;
      if (bus.exp_start) pulses++;
      if (c == 1) begin
        n_checks++;
        if (bus.exp_start !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_exp_start_c1: got %b want 1", bus.exp_start);
        end
      end
      if (bus.key_valid === 1'b1) rise = c;
      else begin
        n_checks++;
        if (bus.req_ready !== 2'b00) begin
          n_fail++;
          $display("FAIL reset_no_grant: cycle %0d req_ready=%b want 00", c, bus.req_ready);
        end
      end
    end
    n_checks++;
    if (rise != EXP_DLY + 2) begin
      n_fail++;
      $display("FAIL reset_key_valid_cycle: got %0d want %0d", rise, EXP_DLY + 2);
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL reset_exp_pulses: got %0d want 1", pulses);
    end
    n_checks++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_grant_after_key: got %b want 01", bus.req_ready);
    end
    bus.req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_single_decipher();
    logic [1:0]      g;
    int              waited;
    logic [SB_W-1:0] exp;
    logic [SB_W-1:0] got;
    bus.req_mode  = 2'b01;
    bus.req_a     = {32'h0, 32'h21A5DBEE};
    bus.req_b     = {32'h0, 32'h154B8F6D};
    bus.req_valid = 2'b01;
    exp_q.push_back({1'b0, 32'hDE5A2411, 32'hEAB47092});
    wait_grant(20, g, waited);
    bus.req_valid = 2'b00;
    n_checks++;
    if (g !== 2'b01 || waited != 0) begin
      n_fail++;
      $display("FAIL dec_grant: got %b after %0d cycles, want 01 after 0", g, waited);
    end
    n_checks++;
    if ({bus.eng_start, bus.eng_mode, bus.s_owner} !== 3'b111) begin
      n_fail++;
      $display("FAIL dec_eng_start: start/mode/owner=%b%b%b want 111", bus.eng_start, bus.eng_mode, bus.s_owner);
    end
    n_checks++;
    if (bus.eng_a !== 32'h21A5DBEE || bus.eng_b !== 32'h154B8F6D) begin
      n_fail++;
      $display("FAIL dec_operands: got %h/%h want 21a5dbee/154b8f6d", bus.eng_a, bus.eng_b);
    end
    @(negedge clk);
    n_checks++;
    if (bus.eng_start !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_start_pulse: got %b want 0", bus.eng_start);
    end
    wait_resp(30, waited);
    n_checks++;
    if (waited != ENG_DLY || bus.resp_valid !== 2'b01) begin
      n_fail++;
      $display("FAIL dec_resp_latency: resp_valid=%b after %0d, want 01 after %0d", bus.resp_valid, waited, ENG_DLY);
    end
    got = {bus.resp_valid[1], bus.resp_a, bus.resp_b};
    if (exp_q.size() == 0) exp = '1;
    else exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL dec_result: got %h want %h", got, exp);
    end
    bus.resp_ready = 2'b10;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 2'b01 || {bus.resp_a, bus.resp_b} !== exp[2*W-1:0] || bus.s_owner !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_hold: resp_valid=%b data=%h%h owner=%b, want 01 %h 0",
               bus.resp_valid, bus.resp_a, bus.resp_b, bus.s_owner, exp[2*W-1:0]);
    end
    ack_resp(2'b01);
    #1;
    n_checks++;
    if (bus.resp_valid !== 2'b00 || bus.dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL dec_ack: resp_valid=%b state=%0d want 00/0", bus.resp_valid, bus.dbg_state);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]      g;
    int              waited;
    logic            want;
    logic [SB_W-1:0] exp;
    logic [SB_W-1:0] got;
    new_ops(0);
    new_ops(1);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      want      = ~model_ptr;
      model_ptr = want;
      wait_grant(20, g, waited);
      n_checks++;
      if (g !== (2'b01 << want) || waited != 0) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: got %b after %0d, want %b after 0", k, g, waited, 2'b01 << want);
      end
      n_checks++;
      if (bus.eng_mode !== cur_mode[want] || bus.eng_a !== cur_a[want]) begin
        n_fail++;
        $display("FAIL rr_operands_%0d: mode=%b a=%h want %b %h", k, bus.eng_mode, bus.eng_a, cur_mode[want], cur_a[want]);
      end
      exp_q.push_back({want, ~cur_a[want], ~cur_b[want]});
      new_ops(int'(want));
      wait_resp(30, waited);
      n_checks++;
      if (bus.resp_valid !== (2'b01 << want)) begin
        n_fail++;
        $display("FAIL rr_resp_bit_%0d: got %b want %b", k, bus.resp_valid, 2'b01 << want);
      end
      got = {bus.resp_valid[1], bus.resp_a, bus.resp_b};
      if (exp_q.size() == 0) exp = '1;
      else exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rr_result_%0d: got %h want %h", k, got, exp);
      end
      ack_resp(2'b01 << want);
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_key_update_mid_block();
    logic [1:0]      g;
    int              waited;
    int              rise;
    logic [SB_W-1:0] exp;
    logic [SB_W-1:0] got;
    new_ops(1);
    bus.req_valid = 2'b10;
    wait_grant(20, g, waited);
    n_checks++;
    if (g !== 2'b10) begin
      n_fail++;
      $display("FAIL ku_grant: got %b want 10", g);
    end
    exp_q.push_back({1'b1, ~cur_a[1], ~cur_b[1]});
    new_ops(0);
    bus.req_valid  = 2'b01;
    bus.key_update = 1'b1;
    @(negedge clk);
    bus.key_update = 1'b0;
    #1;
    n_checks++;
    if (bus.key_valid !== 1'b0 || bus.s_owner !== 1'b1 || bus.req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL ku_key_drop: key_valid=%b s_owner=%b req_ready=%b want 0/1/00", bus.key_valid, bus.s_owner, bus.req_ready);
    end
    wait_resp(30, waited);
    got = {bus.resp_valid[1], bus.resp_a, bus.resp_b};
    if (exp_q.size() == 0) exp = '1;
    else exp = exp_q.pop_front();
    n_checks++;
    if (bus.resp_valid !== 2'b10 || got !== exp) begin
      n_fail++;
      $display("FAIL ku_result: resp_valid=%b got %h want 10 %h", bus.resp_valid, got, exp);
    end
    ack_resp(2'b10);
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b00 || bus.exp_start !== 1'b0) begin
      n_fail++;
      $display("FAIL ku_idle_stale: req_ready=%b exp_start=%b want 00/0", bus.req_ready, bus.exp_start);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.exp_start !== 1'b1 || bus.dbg_state !== 2'd1) begin
      n_fail++;
      $display("FAIL ku_reexpand: exp_start=%b state=%0d want 1/1", bus.exp_start, bus.dbg_state);
    end
    rise = 0;
    for (int c = 1; c <= 20 && rise == 0; c++) begin
      @(negedge clk);
      #1;
      if (bus.key_valid === 1'b1) rise = c;
      else begin
        n_checks++;
        if (bus.req_ready !== 2'b00) begin
          n_fail++;
          $display("FAIL ku_wait_exp: cycle %0d req_ready=%b want 00", c, bus.req_ready);
        end
      end
    end
    n_checks++;
    if (rise != EXP_DLY + 1) begin
      n_fail++;
      $display("FAIL ku_key_valid_cycle: got %0d want %0d", rise, EXP_DLY + 1);
    end
    wait_grant(5, g, waited);
    bus.req_valid = 2'b00;
    n_checks++;
    if (g !== 2'b01 || waited != 0) begin
      n_fail++;
      $display("FAIL ku_late_grant: got %b after %0d want 01 after 0", g, waited);
    end
    exp_q.push_back({1'b0, ~cur_a[0], ~cur_b[0]});
    wait_resp(30, waited);
    got = {bus.resp_valid[1], bus.resp_a, bus.resp_b};
    if (exp_q.size() == 0) exp = '1;
    else exp = exp_q.pop_front();
    n_checks++;
    if (bus.resp_valid !== 2'b01 || got !== exp) begin
      n_fail++;
      $display("FAIL ku_late_result: resp_valid=%b got %h want 01 %h", bus.resp_valid, got, exp);
    end
    ack_resp(2'b01);
  endtask

  task automatic test_backpressure();
    logic [1:0]      g;
    int              waited;
    logic [SB_W-1:0] exp;
    logic [SB_W-1:0] got;
    new_ops(1);
    bus.req_valid = 2'b10;
    wait_grant(20, g, waited);
    n_checks++;
    if (g !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_grant: got %b want 10", g);
    end
    exp_q.push_back({1'b1, ~cur_a[1], ~cur_b[1]});
    new_ops(1);
    wait_resp(30, waited);
    got = {bus.resp_valid[1], bus.resp_a, bus.resp_b};
    if (exp_q.size() == 0) exp = '1;
    else exp = exp_q.pop_front();
    n_checks++;
    if (bus.resp_valid !== 2'b10 || got !== exp) begin
      n_fail++;
      $display("FAIL bp_result: resp_valid=%b got %h want 10 %h", bus.resp_valid, got, exp);
    end
    bus.resp_ready = 2'b01;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.resp_valid !== 2'b10 || {bus.resp_a, bus.resp_b} !== exp[2*W-1:0] || bus.req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: resp_valid=%b data=%h%h req_ready=%b want 10 %h 00",
                 c, bus.resp_valid, bus.resp_a, bus.resp_b, bus.req_ready, exp[2*W-1:0]);
      end
    end
    ack_resp(2'b10);
    wait_grant(20, g, waited);
    bus.req_valid = 2'b00;
    n_checks++;
    if (g !== 2'b10 || waited != 0) begin
      n_fail++;
      $display("FAIL bp_next_grant: got %b after %0d want 10 after 0", g, waited);
    end
    exp_q.push_back({1'b1, ~cur_a[1], ~cur_b[1]});
    wait_resp(30, waited);
    got = {bus.resp_valid[1], bus.resp_a, bus.resp_b};
    if (exp_q.size() == 0) exp = '1;
    else exp = exp_q.pop_front();
    n_checks++;
    if (bus.resp_valid !== 2'b10 || got !== exp) begin
      n_fail++;
      $display("FAIL bp_second_result: resp_valid=%b got %h want 10 %h", bus.resp_valid, got, exp);
    end
    ack_resp(2'b10);
  endtask

  task automatic test_async_reset();
    logic [1:0] g;
    int         waited;
    int         rise;
    cur_a[0]    = $urandom | 32'h1;
    cur_b[0]    = $urandom | 32'h1;
    cur_mode[0] = 1'b1;
    drive_ops();
    bus.req_valid = 2'b01;
    wait_grant(20, g, waited);
    bus.req_valid = 2'b00;
    n_checks++;
    if (g !== 2'b01 || bus.eng_start !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_start: grant=%b eng_start=%b want 01/1", g, bus.eng_start);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.eng_start, bus.eng_mode, bus.s_owner, bus.key_valid, bus.resp_valid, bus.dbg_state} !== '0 ||
        bus.eng_a !== '0 || bus.eng_b !== '0) begin
      n_fail++;
      $display("FAIL ar_outputs: mode=%b owner=%b key_valid=%b eng_a=%h state=%0d want all 0",
               bus.eng_mode, bus.s_owner, bus.key_valid, bus.eng_a, bus.dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.exp_start !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_reexpand: exp_start=%b want 1", bus.exp_start);
    end
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (bus.resp_valid !== 2'b00 || bus.dbg_state !== 2'd1) begin
      n_fail++;
      $display("FAIL ar_late_done: resp_valid=%b state=%0d want 00/1", bus.resp_valid, bus.dbg_state);
    end
    rise = 0;
    for (int c = 1; c <= 20 && rise == 0; c++) begin
      @(negedge clk);
      if (bus.key_valid === 1'b1) rise = c;
    end
    n_checks++;
    if (rise != EXP_DLY - 1) begin
      n_fail++;
      $display("FAIL ar_key_valid_cycle: got %0d want %0d", rise, EXP_DLY - 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_update = 1'b0;
    bus.req_valid  = 2'b00;
    bus.req_mode   = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 2'b00;
    cur_a[0] = '0; cur_a[1] = '0;
    cur_b[0] = '0; cur_b[1] = '0;
    test_reset();
    test_single_decipher();
    test_round_robin();
    test_key_update_mid_block();
    test_backpressure();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
